demux2_buf: RTL
===============

# demux2_buf

Buffered 1-to-2 stream demultiplexer: the routing counterpart of the `Mux2` select primitive. It steers each accepted input word to output channel 0 or 1 according to a per-word select bit, with valid/ready handshakes on every side. Each channel has its own 2-entry FIFO, so a stalled channel never blocks traffic bound for the other one. It sits on the CPU-side write path, where the bridge splits store traffic between data memory (channel 0) and peripherals (channel 1).

## Interface
- `WIDTH`, default 32, data word width in bits.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `In` input WIDTH: input data word.
- `Slt` input 1: channel select for `In`; 0 routes to channel 0, 1 routes to channel 1.
- `InValid` input 1: `In` and `Slt` are valid this cycle.
- `InReady` output 1: the block can accept `In` this cycle.
- `Out0` output WIDTH: head word of the channel-0 FIFO.
- `Out0Valid` output 1: channel-0 FIFO is non-empty.
- `Out0Ready` input 1: downstream consumer 0 takes `Out0` this cycle.
- `Out1`, `Out1Valid`, `Out1Ready`: same as the three channel-0 ports, for channel 1.

## Operation
**Input handshake**
- An accept happens when `InValid && InReady`.
- `InReady` = (`Slt`==0 ? count0<2 : count1<2).
- `InReady` is combinational from `Slt` and the selected FIFO's count. It does not depend on `InValid` or on either `OutXReady`.
- A full FIFO does not pass data through, even when it is being popped in the same cycle.

**Push**
- On an accept, the word is written at the write pointer of the selected FIFO only.
- The other FIFO is untouched.

**Pop**
- A pop of channel X happens when `OutXValid && OutXReady`.
- The read pointer advances by one. `OutX` then shows the next entry, or holds the stale value if the FIFO became empty.

**FIFO state per channel**
- 1-bit write pointer, 1-bit read pointer, and a count in 0..2.
- Pointers wrap from 1 to 0.
- Count update: push only, +1; pop only, −1; push and pop together, unchanged.

**Ordering**
- Each channel preserves input order.
- No ordering is guaranteed between the two channels.

**Outputs**
- `OutXValid` = (countX != 0).
- `OutX` = `mem[rd_ptr]`.
- `OutXValid` must not depend combinationally on `OutXReady`.

**Reset** (`reset` low, at any time, mid-transfer included)
- Pointers and counts go to 0 immediately, so `Out0Valid` = `Out1Valid` = 0.
- Data registers go to 0, so `Out0` = `Out1` = 0.
- `InReady` = 1 for either `Slt` value.
- Words in flight are discarded. No partial state survives deassertion.

## Timing
- Latency from accept to `OutXValid` is 1 cycle: a word accepted at edge N is visible on `OutX` after edge N.
- Throughput per channel is one word per cycle when the consumer keeps `OutXReady` high.
- When `InValid` is low, the values on `In` and `Slt` are ignored.
- Empty FIFO with push and pop in the same cycle: a pop is impossible (valid=0), so this is a plain push.
- Full channel 0 does not affect channel 1: `Slt`=1 words are still accepted.

## Structure
- There is no shared package. The only constant is the FIFO depth (2), fixed as a localparam inside the sub-module.
- One sub-module, `fifo2` (parameter `WIDTH`), is instantiated twice.
  - Ports: `clk`, `reset`, `push`, `din`, `pop`, `dout`, `full`, `empty`.
- The top level contains only the accept/select logic and the `InReady` mux.

## Test plan
- **Reset:** hold `reset`=0 → `Out0Valid`=`Out1Valid`=0, `Out0`=`Out1`=0, `InReady`=1. Release → still idle.
- **Basic routing:** with both readies high, send 0x11111111 (`Slt`=0) then 0x22222222 (`Slt`=1) on consecutive cycles → `Out0`=0x11111111 valid one cycle after its accept, `Out1`=0x22222222 valid one cycle after its accept. Nothing ever appears on the wrong channel.
- **Full channel and head-of-line isolation:** `Out0Ready`=0; push 0xA0, 0xA1, 0xA2 to channel 0 → first two accepted, `InReady`=0 for the third. Then present 0xB0 with `Slt`=1 → accepted and appears on `Out1`. Raise `Out0Ready` → `Out0` delivers 0xA0 then 0xA1.
- **Full with simultaneous pop:** channel 0 full with 0xC0, 0xC1; `Out0Ready`=1 and 0xC2 presented in the same cycle → 0xC2 is refused that cycle and accepted the next. Output order is 0xC0, 0xC1, 0xC2.
- **Streaming and wrap-around:** with `Out1Ready`=1, send 8 consecutive channel-1 words 0..7 → `Out1` shows 0..7 on consecutive cycles. Count never exceeds 1 and the pointers wrap without loss.
- **Reset mid-operation:** both FIFOs hold 2 words; assert `reset` asynchronously between edges → both valids drop before the next edge. After release, a new word 0x55 on channel 1 is the first word delivered.

Source files
------------

// File: rtl/demux2_buf_fifo2.sv
// fifo2: two-entry FIFO used as the per-channel buffer of demux2_buf.
// Storage, pointers and count all clear on reset, so the head word reads 0 when idle.
// A full FIFO refuses a push even if it is popped in the same cycle.
module fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 2;
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    // Next count: push-only adds one, pop-only removes one, both cancel out.
    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 2'd1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 2'd1;
        end
    end

    // Pointer and count registers; 1-bit pointers wrap from 1 back to 0 on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // One register per entry, written only when the write pointer selects it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_reg[gi] <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end
endmodule

// File: rtl/demux2_buf.sv
// demux2_buf: buffered 1-to-2 stream demultiplexer. Each input word goes to
// channel 0 or 1 by Slt; each channel has its own fifo2 so a stalled channel
// never blocks traffic to the other one.
module demux2_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] In,
    input  logic             Slt,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out0,
    output logic             Out0Valid,
    input  logic             Out0Ready,
    output logic [WIDTH-1:0] Out1,
    output logic             Out1Valid,
    input  logic             Out1Ready
);
    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic accept;
    logic push0;
    logic push1;

    // Readiness depends only on the selected channel's fullness, never on the
    // output readies, so a full FIFO does not pass data through on a pop.
    assign InReady = Slt ? !full1 : !full0;
    assign accept  = InValid && InReady;
    assign push0   = accept && !Slt;
    assign push1   = accept && Slt;

    assign Out0Valid = !empty0;
    assign Out1Valid = !empty1;

    fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .din   (In),
        .pop   (Out0Ready),
        .dout  (Out0),
        .full  (full0),
        .empty (empty0)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .din   (In),
        .pop   (Out1Ready),
        .dout  (Out1),
        .full  (full1),
        .empty (empty1)
    );
endmodule
